// File: rtl/alu_muldiv.sv
// MIPS-style ALU with iterative shift-add multiplier and HI/LO registers.
// Define ALU_MULDIV_DIV_EN to add the restoring divider (div/divu) and its DIV state.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
`ifdef ALU_MULDIV_DIV_EN
    localparam logic [1:0] DIV  = 2'd2;
`endif
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef ALU_MULDIV_DIV_EN
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   opnd;
    logic               neg_a;
    logic               neg_b;

    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               last;
    logic               start_mul;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_prod;

    // func[0] clear selects the signed variant of mult/div.
    assign sgn_a = ~func[0] & a[WIDTH-1];
    assign sgn_b = ~func[0] & b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;
    assign last  = (cnt == CW'(WIDTH - 1));
    assign start_mul = (state == IDLE) && start && (aluop == 2'b10) && (func[5:1] == 5'b01100);

    // Upper half accumulates the multiplicand when the multiplier LSB is set, then all shifts right.
    assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, work[WIDTH-1:1]};
    assign mul_prod = (neg_a ^ neg_b) ? -mul_next : mul_next;

`ifdef ALU_MULDIV_DIV_EN
    logic               start_div;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic [WIDTH-1:0]   div_dz_hi;
    logic [2*WIDTH-1:0] div_next;

    assign start_div = (state == IDLE) && start && (aluop == 2'b10) && (func[5:1] == 5'b01101);
    // work = {remainder, dividend/quotient}; one quotient bit enters at the LSB per cycle.
    assign div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_sub   = div_shift[WIDTH-1:0] - opnd;
    assign div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), work[WIDTH-2:0], div_ge};
    assign div_q     = (neg_a ^ neg_b) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign div_r     = neg_a ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    // work still holds |a| when the divisor is zero, so re-apply the sign to recover a.
    assign div_dz_hi = neg_a ? -work[WIDTH-1:0] : work[WIDTH-1:0];

    assign busy = (state == MUL) || (state == DIV);
`else
    assign busy = (state == MUL);
`endif
    assign done = (state == DONE);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (aluop)
            2'b00: result = a + b;
            2'b01: result = a - b;
            2'b10: begin
                case (func)
                    F_ADD:   result = a + b;
                    F_SUB:   result = a - b;
                    F_AND:   result = a & b;
                    F_OR:    result = a | b;
                    F_XOR:   result = a ^ b;
                    F_NOR:   result = ~(a | b);
                    F_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    F_SLTU:  result = {{(WIDTH-1){1'b0}}, (a < b)};
                    F_MFHI:  result = hi;
                    F_MFLO:  result = lo;
                    F_MULT,
                    F_MULTU: result = '0;
`ifdef ALU_MULDIV_DIV_EN
                    F_DIV,
                    F_DIVU:  result = '0;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            work  <= '0;
            opnd  <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        state <= MUL;
                        cnt   <= '0;
                        work  <= {{WIDTH{1'b0}}, mag_b};
                        opnd  <= mag_a;
                        neg_a <= sgn_a;
                        neg_b <= sgn_b;
                    end
`ifdef ALU_MULDIV_DIV_EN
                    else if (start_div) begin
                        state <= DIV;
                        cnt   <= '0;
                        work  <= {{WIDTH{1'b0}}, mag_a};
                        opnd  <= mag_b;
                        neg_a <= sgn_a;
                        neg_b <= sgn_b;
                    end
`endif
                end
                MUL: begin
                    work <= mul_next;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        hi    <= mul_prod[2*WIDTH-1:WIDTH];
                        lo    <= mul_prod[WIDTH-1:0];
                    end
                end
`ifdef ALU_MULDIV_DIV_EN
                DIV: begin
                    if (opnd == '0) begin
                        state <= DONE;
                        hi    <= div_dz_hi;
                        lo    <= '1;
                    end else begin
                        work <= div_next;
                        cnt  <= cnt + 1'b1;
                        if (last) begin
                            state <= DONE;
                            hi    <= div_r;
                            lo    <= div_q;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
